// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port stack-machine memory arbiter.
// Optional round-robin arbitration is selected with MEM_ARB_RR_EN.
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef logic port_id_t;
    localparam port_id_t PORT_FETCH = 1'b0;
    localparam port_id_t PORT_DATA  = 1'b1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant for the fetch (bit 0) and data (bit 1) ports, one-hot.
// MEM_ARB_RR_EN: ties go to the port not granted last; otherwise data always wins.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic       i_p0_valid,
    input  logic       i_p1_valid,
`ifdef MEM_ARB_RR_EN
    input  port_id_t   i_last,
`endif
    output logic [1:0] o_grant
);

    // Pick at most one requester.
    always_comb begin
        o_grant = 2'b00;
        if (i_p0_valid && i_p1_valid) begin
`ifdef MEM_ARB_RR_EN
            o_grant = (i_last == PORT_FETCH) ? 2'b10 : 2'b01;
`else
            o_grant = 2'b10;
`endif
        end else if (i_p1_valid) begin
            o_grant = 2'b10;
        end else if (i_p0_valid) begin
            o_grant = 2'b01;
        end else begin
            o_grant = 2'b00;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Non-pipelined arbiter sharing one memory port between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin tie breaking instead of fixed data-port priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = mem_arb_pkg::ADDR_W,
    parameter int DATA_W     = mem_arb_pkg::DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    input  logic [ADDR_W-1:0] p0_req_addr,
    output logic              p0_req_ready,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_req_valid,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_req_ready,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] LAT_M1 = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

    arb_state_t        r_state;
    port_id_t          r_port;
    mem_req_t          r_req;
    logic              r_mem_we;
    logic [1:0]        r_cnt;
    logic              r_p0_rsp_valid;
    logic              r_p1_rsp_valid;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;
`ifdef MEM_ARB_RR_EN
    port_id_t          r_last;
`endif

    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_resp_go;
    logic [DATA_W-1:0] w_resp_data;

    mem_arb_grant u_grant (
        .i_p0_valid (p0_req_valid),
        .i_p1_valid (p1_req_valid),
`ifdef MEM_ARB_RR_EN
        .i_last     (r_last),
`endif
        .o_grant    (w_grant)
    );

    // Ready is suppressed while reset is asserted so no requester sees a phantom accept.
    assign w_accept     = (r_state == IDLE) && !rst;
    assign p0_req_ready = w_accept && w_grant[0];
    assign p1_req_ready = w_accept && w_grant[1];

    assign mem_addr     = r_req.addr;
    assign mem_wdata    = r_req.wdata;
    assign mem_we       = r_mem_we;
    assign p0_rsp_valid = r_p0_rsp_valid;
    assign p1_rsp_valid = r_p1_rsp_valid;
    assign p0_rsp_rdata = r_p0_rdata;
    assign p1_rsp_rdata = r_p1_rdata;

    // Decide when the transaction completes and which data it returns.
    always_comb begin
        w_resp_go   = 1'b0;
        w_resp_data = '0;
        if (r_state == ACCESS && (r_req.we || RD_LATENCY == 0)) begin
            w_resp_go   = 1'b1;
            w_resp_data = r_req.we ? '0 : mem_rdata;
        end else if (r_state == WAIT && r_cnt == 2'd0) begin
            w_resp_go   = 1'b1;
            w_resp_data = mem_rdata;
        end else begin
            w_resp_go   = 1'b0;
            w_resp_data = '0;
        end
    end

    // Transaction FSM with registered memory-side and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_port         <= PORT_FETCH;
            r_req          <= '0;
            r_mem_we       <= 1'b0;
            r_cnt          <= 2'd0;
            r_p0_rsp_valid <= 1'b0;
            r_p1_rsp_valid <= 1'b0;
            r_p0_rdata     <= '0;
            r_p1_rdata     <= '0;
`ifdef MEM_ARB_RR_EN
            r_last         <= PORT_FETCH;
`endif
        end else begin
            r_mem_we       <= 1'b0;
            r_p0_rsp_valid <= 1'b0;
            r_p1_rsp_valid <= 1'b0;
            if (w_resp_go) begin
                if (r_port == PORT_DATA) begin
                    r_p1_rsp_valid <= 1'b1;
                    r_p1_rdata     <= w_resp_data;
                end else begin
                    r_p0_rsp_valid <= 1'b1;
                    r_p0_rdata     <= w_resp_data;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_port     <= w_grant[1] ? PORT_DATA : PORT_FETCH;
                        r_req.addr <= w_grant[1] ? p1_req_addr : p0_req_addr;
                        r_req.we   <= w_grant[1] && p1_req_we;
                        r_mem_we   <= w_grant[1] && p1_req_we;
                        // Fetches carry no write data, so the last written value stays on the pins.
                        if (w_grant[1]) begin
                            r_req.wdata <= p1_req_wdata;
                        end
`ifdef MEM_ARB_RR_EN
                        r_last     <= w_grant[1] ? PORT_DATA : PORT_FETCH;
`endif
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_resp_go) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt   <= LAT_M1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_resp_go) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances with RD_LATENCY 1, 3 and 0.
// Build with MEM_ARB_RR_EN defined to exercise round-robin contention expectations.
module tb_mem_arbiter;

    localparam int NI = 3;
    localparam int LATS [NI] = '{1, 3, 0};

    typedef struct {
        int         k;
        int         port;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst          [NI];
    logic       p0_req_valid [NI];
    logic [7:0] p0_req_addr  [NI];
    logic       p0_req_ready [NI];
    logic       p0_rsp_valid [NI];
    logic [7:0] p0_rsp_rdata [NI];
    logic       p1_req_valid [NI];
    logic       p1_req_we    [NI];
    logic [7:0] p1_req_addr  [NI];
    logic [7:0] p1_req_wdata [NI];
    logic       p1_req_ready [NI];
    logic       p1_rsp_valid [NI];
    logic [7:0] p1_rsp_rdata [NI];
    logic [7:0] mem_addr     [NI];
    logic       mem_we       [NI];
    logic [7:0] mem_wdata    [NI];
    logic [7:0] mem_rdata    [NI];

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   we_cnt [NI];

    // Memory contents: address XOR 0xC3, except 0x10 which holds 0x5A.
    function automatic logic [7:0] mem_init(input logic [7:0] a);
        return (a == 8'h10) ? 8'h5A : (a ^ 8'hC3);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [7:0] mem [256];
        initial for (int a = 0; a < 256; a++) mem[a] <= mem_init(8'(a));
        always @(posedge clk) if (mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
        assign mem_rdata[g] = mem[mem_addr[g]];

        mem_arbiter #(.RD_LATENCY(LATS[g])) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .p0_req_valid (p0_req_valid[g]),
            .p0_req_addr  (p0_req_addr[g]),
            .p0_req_ready (p0_req_ready[g]),
            .p0_rsp_valid (p0_rsp_valid[g]),
            .p0_rsp_rdata (p0_rsp_rdata[g]),
            .p1_req_valid (p1_req_valid[g]),
            .p1_req_we    (p1_req_we[g]),
            .p1_req_addr  (p1_req_addr[g]),
            .p1_req_wdata (p1_req_wdata[g]),
            .p1_req_ready (p1_req_ready[g]),
            .p1_rsp_valid (p1_rsp_valid[g]),
            .p1_rsp_rdata (p1_rsp_rdata[g]),
            .mem_addr     (mem_addr[g]),
            .mem_we       (mem_we[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_rdata    (mem_rdata[g])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the head of the scoreboard.
    always @(negedge clk) begin : mon
        logic       v;
        logic [7:0] d;
        exp_t       e;
        for (int k = 0; k < NI; k++) begin
            if (mem_we[k]) we_cnt[k]++;
            for (int p = 0; p < 2; p++) begin
                v = (p == 0) ? p0_rsp_valid[k] : p1_rsp_valid[k];
                d = (p == 0) ? p0_rsp_rdata[k] : p1_rsp_rdata[k];
                if (v) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_rsp: inst %0d port %0d data 0x%0h cycle %0d, none expected",
                                 k, p, d, cyc);
                    end else begin
                        e = sbq.pop_front();
                        if (e.k != k || e.port != p || e.data != d || e.cyc != cyc) begin
                            failures++;
                            $display("FAIL rsp: got inst %0d port %0d data 0x%0h cycle %0d, expected inst %0d port %0d data 0x%0h cycle %0d",
                                     k, p, d, cyc, e.k, e.port, e.data, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic push_exp(input int k, input int port, input logic we, input logic [7:0] d, input int acc);
        exp_t e;
        e.k    = k;
        e.port = port;
        e.data = we ? 8'h00 : d;
        e.cyc  = acc + (we ? 2 : 2 + LATS[k]);
        sbq.push_back(e);
    endtask

    // Issue one request, wait (bounded) for ready, queue its expected response.
    task automatic req(input int k, input int port, input logic we, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_d, output int acc);
        @(posedge clk); #1;
        if (port == 0) begin
            p0_req_valid[k] = 1'b1;
            p0_req_addr[k]  = addr;
        end else begin
            p1_req_valid[k] = 1'b1;
            p1_req_we[k]    = we;
            p1_req_addr[k]  = addr;
            p1_req_wdata[k] = wdata;
        end
        acc = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            @(negedge clk);
            if ((port == 0) ? p0_req_ready[k] : p1_req_ready[k]) begin
                acc = cyc;
                push_exp(k, port, we, exp_d, acc);
            end
        end
        if (acc < 0) check("req_timeout", 0, 1);
        @(posedge clk); #1;
        p0_req_valid[k] = 1'b0;
        p1_req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
        check("drain", sbq.size(), 0);
    endtask

    initial begin : stim
        int acc;
        int prev;
        int we0;
        int gp;
        int exp_seq [4];
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1;
            p0_req_valid[k] = 1'b0; p0_req_addr[k] = 8'h00;
            p1_req_valid[k] = 1'b0; p1_req_we[k] = 1'b0;
            p1_req_addr[k]  = 8'h00; p1_req_wdata[k] = 8'h00;
            we_cnt[k] = 0;
        end

        // Reset held with both ports requesting on instance 0.
        p0_req_valid[0] = 1'b1; p0_req_addr[0] = 8'h10;
        p1_req_valid[0] = 1'b1; p1_req_addr[0] = 8'h20;
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", {p0_req_ready[0], p1_req_ready[0]}, 0);
            check("rst_mem_we", mem_we[0], 0);
            check("rst_mem_addr", mem_addr[0], 0);
            check("rst_rsp_valid", {p0_rsp_valid[0], p1_rsp_valid[0]}, 0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(negedge clk);
        check("first_grant", {p1_req_ready[0], p0_req_ready[0]}, 2);
        push_exp(0, 1, 1'b0, 8'hE3, cyc);
        @(posedge clk); #1;
        p1_req_valid[0] = 1'b0;

        // Fetch of 0x10 (still pending) follows once the data read completes.
        acc = -1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            @(negedge clk);
            if (p0_req_ready[0]) begin
                acc = cyc;
                push_exp(0, 0, 1'b0, 8'h5A, acc);
            end
        end
        if (acc < 0) check("fetch_timeout", 0, 1);
        @(posedge clk); #1;
        p0_req_valid[0] = 1'b0;
        check("fetch_mem_addr", mem_addr[0], 8'h10);
        drain();

        // Data write then read-back on the same address.
        we0 = we_cnt[0];
        req(0, 1, 1'b1, 8'h80, 8'h33, 8'h00, acc);
        check("write_mem_we", mem_we[0], 1);
        check("write_mem_wdata", mem_wdata[0], 8'h33);
        drain();
        check("write_we_pulses", we_cnt[0] - we0, 1);
        req(0, 1, 1'b0, 8'h80, 8'h00, 8'h33, acc);
        drain();

        // Contention on a fresh instance so the round-robin pointer is at its reset value.
`ifdef MEM_ARB_RR_EN
        exp_seq = '{1, 0, 1, 0};
`else
        exp_seq = '{1, 1, 1, 1};
`endif
        @(posedge clk); #1;
        p0_req_valid[2] = 1'b1; p0_req_addr[2] = 8'h11;
        p1_req_valid[2] = 1'b1; p1_req_we[2] = 1'b0; p1_req_addr[2] = 8'h22;
        for (int g = 0; g < 4; g++) begin
            gp = -1;
            for (int i = 0; i < 20 && gp < 0; i++) begin
                @(negedge clk);
                if (p1_req_ready[2]) begin
                    gp = 1;
                    push_exp(2, 1, 1'b0, 8'hE1, cyc);
                end else if (p0_req_ready[2]) begin
                    gp = 0;
                    push_exp(2, 0, 1'b0, 8'hD2, cyc);
                end
            end
            check($sformatf("contention_grant%0d", g), gp, exp_seq[g]);
        end
        @(posedge clk); #1;
        p0_req_valid[2] = 1'b0;
        p1_req_valid[2] = 1'b0;
        drain();

        // RD_LATENCY=0 single fetch, then back-to-back fetches every 3 cycles.
        req(2, 0, 1'b0, 8'h10, 8'h00, 8'h5A, acc);
        drain();
        @(posedge clk); #1;
        p0_req_valid[2] = 1'b1; p0_req_addr[2] = 8'h12;
        prev = -1;
        for (int n = 0; n < 3; n++) begin
            acc = -1;
            for (int i = 0; i < 20 && acc < 0; i++) begin
                @(negedge clk);
                if (p0_req_ready[2]) begin
                    acc = cyc;
                    push_exp(2, 0, 1'b0, 8'hD1, acc);
                end
            end
            if (prev >= 0) check($sformatf("b2b_spacing%0d", n), acc - prev, 3);
            prev = acc;
        end
        @(posedge clk); #1;
        p0_req_valid[2] = 1'b0;
        drain();

        // RD_LATENCY=3 read, then a read abandoned by reset during WAIT.
        req(1, 0, 1'b0, 8'h40, 8'h00, 8'h83, acc);
        drain();
        @(posedge clk); #1;
        p0_req_valid[1] = 1'b1; p0_req_addr[1] = 8'h44;
        @(negedge clk);
        check("rst_mid_accept", p0_req_ready[1], 1);
        @(posedge clk); #1;
        p0_req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        p0_req_valid[1] = 1'b1; p0_req_addr[1] = 8'h41;
        @(negedge clk);
        check("idle_after_rst", p0_req_ready[1], 1);
        push_exp(1, 0, 1'b0, 8'h82, cyc);
        @(posedge clk); #1;
        p0_req_valid[1] = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        check("final_queue_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 8-bit-address, 8-bit-data memory port of the stack machine between two requesters.
  - Port 0 (P0): instruction fetch.
  - Port 1 (P1): stack/data load-store.
- Non-pipelined: one memory transaction in flight at a time.
- Sits between the stack machine core and the memory model/pins. Replaces the core driving the memory address and data directly.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- RD_LATENCY, 1, cycles from address presented to mem_rdata valid; legal range 0..3 (0 = combinational read).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- p0_req_valid  in  1  fetch request.
- p0_req_addr  in  ADDR_W  fetch address.
- p0_req_ready  out  1  fetch request accepted this cycle.
- p0_rsp_valid  out  1  fetch data returned (one-cycle pulse).
- p0_rsp_rdata  out  DATA_W  fetch data.
- p1_req_valid  in  1  data request.
- p1_req_we  in  1  1 = write, 0 = read.
- p1_req_addr  in  ADDR_W  data address.
- p1_req_wdata  in  DATA_W  write data.
- p1_req_ready  out  1  data request accepted this cycle.
- p1_rsp_valid  out  1  read data returned / write acknowledged (one-cycle pulse).
- p1_rsp_rdata  out  DATA_W  read data; 0 for write ack.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - State = IDLE.
  - All ready, rsp_valid and mem_we = 0.
  - mem_addr, mem_wdata, rsp_rdata = 0.
  - Wait counter = 0; RR pointer = P0.
- Reset mid-transaction: the transaction is abandoned; no rsp_valid is issued afterwards.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any req_valid: grant one port (see arbitration). That port's req_ready = 1 combinationally in the same cycle.
  - Latch port id, addr, we, wdata. Go to ACCESS.
  - Never more than one ready high per cycle. Ready is 0 in all other states.
- ACCESS (1 cycle):
  - mem_addr and mem_wdata are driven from the registered latched values.
  - mem_we = 1 only in ACCESS and only for a P1 write.
  - Write, or read with RD_LATENCY=0: go to RESP. For a read, mem_rdata is captured at the end of ACCESS.
  - Read with RD_LATENCY>0: go to WAIT with counter = RD_LATENCY-1.
- WAIT:
  - mem_addr held; mem_we = 0.
  - Counter decrements each cycle.
  - When counter = 0: capture mem_rdata and go to RESP.
- RESP (1 cycle):
  - rsp_valid = 1 for the granted port only. rsp_rdata = captured data (0 for write).
  - Go to IDLE.
  - Requests are not accepted in RESP.
- Latency, with request accepted in cycle N:
  - Read: rsp_valid in cycle N+2+RD_LATENCY.
  - Write: ack in cycle N+2.
  - Throughput: one transaction per 3+RD_LATENCY cycles (write: 3).
- Outside ACCESS/WAIT, mem_addr and mem_wdata hold their last values.
- rsp_rdata holds its value until the next RESP.
- P0 is read-only; it has no we/wdata.
- A requester holds valid/addr stable until ready. Withdrawing valid before ready is legal; no transaction occurs.
- Arbitration, default (fixed priority): P1 wins when both ports are valid in IDLE.
- Addresses are used as-is; ADDR_W-bit, no wrap logic needed.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a tie, the port not granted most recently wins.
  - The pointer updates only on grant.
  - The first tie after reset goes to P1 (pointer reset = P0 = last granted).
- Undefined: fixed P1 priority. No pointer register exists.

Decomposition:
- Package mem_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - Enum arb_state_t {IDLE, ACCESS, WAIT, RESP}.
  - Typedef port_id_t (1 bit) with constants PORT_FETCH = 0, PORT_DATA = 1.
  - Typedef mem_req_t struct {we, addr, wdata}.
- Sub-module mem_arb_grant:
  - Combinational: two valids (plus last-grant under MEM_ARB_RR_EN) -> one-hot grant.
  - Instantiated once.

Test Plan:
- Reset: hold rst for 2 cycles with both ports valid -> no ready, no mem_we, mem_addr=0, no rsp_valid; first grant occurs in the cycle after rst drops.
- Single fetch, RD_LATENCY=1: memory at address 0x10 returns 0x5A; P0 reads 0x10, accepted cycle N -> mem_addr=0x10 at N+1, p0_rsp_valid=1 with 0x5A at N+3 only.
- Data write then read: P1 writes 0x33 to 0x80 -> mem_we=1 for exactly one cycle, ack at N+2 with rdata=0. A following P1 read of 0x80 returns 0x33.
- Contention: both ports valid continuously for 4 grants.
  - Fixed priority: all 4 to P1; P0 starves.
  - With MEM_ARB_RR_EN: P1, P0, P1, P0.
- Reset mid-read: assert rst during WAIT (RD_LATENCY=3) -> no rsp_valid on either port; FSM is IDLE next cycle.
- RD_LATENCY=0: P0 read returns data at N+2; back-to-back requests are accepted every 3 cycles.
